mem_param: RTL and testbench

MEM_PARAM -- requirements
Module: mem_param

---
 rtl/mem_param.sv | 134 +++++++++++++
 tb/tb_mem_param.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_param.sv
`default_nettype none
// ============================================================================
//  Module   : mem_param
//  Purpose  : Single-port word memory with byte enables, self-zeroing sweep
//             after reset and a fixed-latency, fully pipelined response path.
//  Revision : 1.0
// ============================================================================
module mem_param #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 30,
    parameter int DEPTH_LOG2   = 12,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    input  logic                    write_en_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    ready_o,
    output logic                    ack_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    err_o
);

    localparam int C_NBYTES = DATA_WIDTH / 8;
    localparam int C_DEPTH  = 1 << DEPTH_LOG2;

    localparam logic [0:0] C_ST_INIT = 1'b0;
    localparam logic [0:0] C_ST_RUN  = 1'b1;

    localparam logic [DEPTH_LOG2-1:0] C_CNT_LAST = '1;

    logic [0:0]            r_state;
    logic [DEPTH_LOG2-1:0] r_cnt;
    logic [DATA_WIDTH-1:0] r_mem [C_DEPTH];

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_oor;
    logic                  w_wr;
    logic                  w_rd;
    logic [DEPTH_LOG2-1:0] w_idx;

    assign w_ready = (r_state == C_ST_RUN);
    assign w_idx   = addr_i[DEPTH_LOG2-1:0];

    generate
        if (DEPTH_LOG2 < ADDR_WIDTH) begin : g_oor
            assign w_oor = |addr_i[ADDR_WIDTH-1:DEPTH_LOG2];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign w_accept = w_ready & req_i;
    assign w_wr     = w_accept &  write_en_i & ~w_oor;
    assign w_rd     = w_accept & ~write_en_i & ~w_oor;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= C_ST_INIT;
            r_cnt   <= '0;
        end else if (r_state == C_ST_INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == C_CNT_LAST) begin
                r_state <= C_ST_RUN;
            end
        end
    end

    // Storage carries no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk_i) begin
        if (r_state == C_ST_INIT) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr) begin
            for (int b = 0; b < C_NBYTES; b++) begin
                if (be_i[b]) begin
                    r_mem[w_idx][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    logic                  r_s1_ack;
    logic                  r_s1_err;
    logic [DATA_WIDTH-1:0] r_s1_data;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_s1_ack  <= 1'b0;
            r_s1_err  <= 1'b0;
            r_s1_data <= '0;
        end else begin
            r_s1_ack  <= w_accept;
            r_s1_err  <= w_accept & w_oor;
            r_s1_data <= w_rd ? r_mem[w_idx] : '0;
        end
    end

    // Writes travel the same pipe as reads so every ack has equal latency.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s2_ack;
            logic                  r_s2_err;
            logic [DATA_WIDTH-1:0] r_s2_data;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_s2_ack  <= 1'b0;
                    r_s2_err  <= 1'b0;
                    r_s2_data <= '0;
                end else begin
                    r_s2_ack  <= r_s1_ack;
                    r_s2_err  <= r_s1_err;
                    r_s2_data <= r_s1_data;
                end
            end

            assign ack_o   = r_s2_ack;
            assign err_o   = r_s2_err;
            assign rdata_o = r_s2_data;
        end else begin : g_lat1
            assign ack_o   = r_s1_ack;
            assign err_o   = r_s1_err;
            assign rdata_o = r_s1_data;
        end
    endgenerate

    assign ready_o = w_ready;

endmodule
`default_nettype wire

// File: tb/tb_mem_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_param
//  Purpose  : Drives latency-1 and latency-2 instances in lockstep and checks
//             both against an array/queue reference of the memory behaviour.
//  Revision : 1.0
// ============================================================================
module tb_mem_param;

    logic        clk_i      = 1'b0;
    logic        rst_i      = 1'b1;
    logic        req_i      = 1'b0;
    logic        write_en_i = 1'b0;
    logic [5:0]  addr_i     = '0;
    logic [3:0]  be_i       = '0;
    logic [31:0] wdata_i    = '0;

    logic        w_rdy1, w_ack1, w_err1;
    logic [31:0] w_rd1;
    logic        w_rdy2, w_ack2, w_err2;
    logic [31:0] w_rd2;

    always #5 clk_i = ~clk_i;

    mem_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH_LOG2(4), .READ_LATENCY(1)
    ) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_en_i(write_en_i),
        .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i),
        .ready_o(w_rdy1), .ack_o(w_ack1), .rdata_o(w_rd1), .err_o(w_err1)
    );

    mem_param #(
        .DATA_WIDTH(32), .ADDR_WIDTH(6), .DEPTH_LOG2(4), .READ_LATENCY(2)
    ) u_dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .write_en_i(write_en_i),
        .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i),
        .ready_o(w_rdy2), .ack_o(w_ack2), .rdata_o(w_rd2), .err_o(w_err2)
    );

    typedef struct {
        int          due;
        logic        err;
        logic        rd;
        logic [31:0] data;
    } exp_t;

    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] m_mem [16];
    int          rel;
    int          ecnt;
    int          n_vec;
    int          n_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_bad++;
            $display("FAIL %s at edge %0d: observed %0h expected %0h", tag, ecnt, obs, expv);
        end
    endtask

    task automatic chk_one(input string nm, input logic has, input exp_t e,
                           input logic rdy, input logic ack, input logic err,
                           input logic [31:0] rd);
        chk({nm, " ready"}, 64'(rdy), 64'(rel >= 16));
        if (has) begin
            chk({nm, " ack"}, 64'(ack), 64'd1);
            chk({nm, " err"}, 64'(err), 64'(e.err));
            if (e.rd) chk({nm, " rdata"}, 64'(rd), 64'(e.data));
        end else begin
            chk({nm, " idle ack"}, 64'(ack), 64'd0);
            chk({nm, " idle err"}, 64'(err), 64'd0);
            chk({nm, " idle rdata"}, 64'(rd), 64'd0);
        end
    endtask

    task automatic check_all();
        exp_t e;
        logic h;
        e = '{due: 0, err: 1'b0, rd: 1'b0, data: 32'h0};
        h = (q1.size() > 0) && (q1[0].due == ecnt);
        if (h) e = q1.pop_front();
        chk_one("L1", h, e, w_rdy1, w_ack1, w_err1, w_rd1);
        e = '{due: 0, err: 1'b0, rd: 1'b0, data: 32'h0};
        h = (q2.size() > 0) && (q2[0].due == ecnt);
        if (h) e = q2.pop_front();
        chk_one("L2", h, e, w_rdy2, w_ack2, w_err2, w_rd2);
    endtask

    // Apply one cycle of stimulus; called at a negedge, returns at the next one.
    task automatic cyc_do(input logic rq, input logic we, input logic [5:0] a,
                          input logic [3:0] be, input logic [31:0] wd);
        exp_t e;
        req_i = rq; write_en_i = we; addr_i = a; be_i = be; wdata_i = wd;
        @(posedge clk_i);
        ecnt++;
        if (!rst_i) begin
            rel = 0;
        end else begin
            if (rq && rel >= 16) begin
                e.err  = (a >= 6'd16);
                e.rd   = !we;
                e.data = 32'h0;
                if (!e.err) begin
                    if (we) begin
                        for (int b = 0; b < 4; b++)
                            if (be[b]) m_mem[a[3:0]][8*b +: 8] = wd[8*b +: 8];
                    end else begin
                        e.data = m_mem[a[3:0]];
                    end
                end
                e.due = ecnt;     q1.push_back(e);
                e.due = ecnt + 1; q2.push_back(e);
            end
            if (rel < 16) rel++;
        end
        #1 check_all();
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc_do(1'b0, 1'b0, 6'd0, 4'd0, 32'd0);
    endtask

    task automatic wr(input logic [5:0] a, input logic [3:0] be, input logic [31:0] d);
        cyc_do(1'b1, 1'b1, a, be, d);
    endtask

    task automatic rd(input logic [5:0] a);
        cyc_do(1'b1, 1'b0, a, 4'd0, 32'd0);
    endtask

    // Asynchronous assert mid-cycle, outputs checked before any clock edge.
    task automatic do_reset();
        rst_i = 1'b0;
        q1.delete();
        q2.delete();
        rel = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = 32'h0;
        #1 check_all();
        @(negedge clk_i);
        idle(2);
        rst_i = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; ecnt = 0; rel = 0;
        #2;
        do_reset();
        idle(16);
        for (int k = 0; k < 16; k++) rd(6'(k));
        idle(2);

        wr(6'd3, 4'hF, 32'hDEADBEEF);
        wr(6'd3, 4'h5, 32'h11223344);
        rd(6'd3);
        idle(2);

        wr(6'd7, 4'hF, 32'hA5A5A5A5);
        rd(6'd7);
        idle(2);

        wr(6'h10, 4'hF, 32'hFFFFFFFF);
        rd(6'd0);
        wr(6'd9, 4'h0, 32'h12345678);
        rd(6'd9);
        idle(2);

        for (int k = 0; k < 8; k++) wr(6'(k), 4'hF, 32'(k));
        for (int k = 0; k < 8; k++) rd(6'(k));
        idle(2);

        for (int i = 0; i < 400; i++) begin
            cyc_do($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) == 0) ? 6'($urandom_range(16, 63))
                                               : 6'($urandom_range(0, 15)),
                   4'($urandom), $urandom);
        end
        idle(2);

        wr(6'd2, 4'hF, 32'h00000055);
        rd(6'd2);
        do_reset();
        for (int i = 0; i < 16; i++)
            cyc_do(1'b1, 1'($urandom_range(0, 1)), 6'd2, 4'hF, $urandom);
        rd(6'd2);
        idle(2);

        wr(6'd5, 4'hF, 32'hCAFEF00D);
        do_reset();
        idle(5);
        do_reset();
        idle(16);
        for (int k = 0; k < 16; k++) rd(6'(k));
        idle(3);

        chk("drain L1", 64'(q1.size()), 64'd0);
        chk("drain L2", 64'(q2.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
